// File: rtl/uart_tx_cfg.sv
// Purpose : parametrised UART transmitter (data width, even/odd parity, 1/2 stop bits, baud divisor).
// Latency : start bit on uart_out from the accepting edge; tx_done pulses F=(1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles later.
// Backpressure: tx_ready is low for the whole frame; tx_valid while busy is dropped (no queueing).
// Ports   : clk, rst (sync, active-high); tx_valid/tx_data/tx_ready upstream handshake;
//           tx_busy frame in progress; tx_done one-cycle completion pulse; uart_out serial line (idles high).
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 uart_out
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic                 par_bit, par_n;
    logic                 out_n, done_n, ready_n;
    logic                 bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            uart_out  <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            stop_idx  <= stop_idx_n;
            shift_reg <= shift_n;
            par_bit   <= par_n;
            uart_out  <= out_n;
            tx_ready  <= ready_n;
            tx_busy   <= !ready_n;
            tx_done   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shift_n    = shift_reg;
        par_n      = par_bit;
        out_n      = uart_out;
        done_n     = 1'b0;
        bit_end    = (cnt == CNT_LAST);

        // Bit timer runs in every non-idle state and wraps on terminal count.
        if (state != IDLE) begin
            cnt_n = bit_end ? '0 : cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_n    = START;
                    cnt_n      = '0;
                    bit_idx_n  = '0;
                    stop_idx_n = 1'b0;
                    shift_n    = tx_data;
                    // Parity is taken from the captured word because the shift register drains.
                    par_n      = (^tx_data) ^ ODD_BIT;
                    out_n      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    out_n   = shift_reg[0];
                    shift_n = shift_reg >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_n = '0;
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            out_n   = par_bit;
                        end else begin
                            state_n = STOP;
                            out_n   = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + IW'(1);
                        out_n     = shift_reg[0];
                        shift_n   = shift_reg >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    out_n   = 1'b1;
                end
            end
            STOP: begin
                out_n = 1'b1;
                if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        state_n    = IDLE;
                        stop_idx_n = 1'b0;
                        done_n     = 1'b1;
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                cnt_n      = '0;
                bit_idx_n  = '0;
                stop_idx_n = 1'b0;
                out_n      = 1'b1;
            end
        endcase

        ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Purpose : scoreboard bench for uart_tx_cfg across four frame formats (8N1/434, 8E1/4, 8O1/4, 7N2/4).
// Latency : expected frames are queued at issue; per-instance monitors check each line sample and the done pulse.
// Backpressure: stimulus only issues when the instance is idle, except deliberate busy-period tx_valid pulses.
module tb_uart_tx_cfg;

    typedef struct packed {
        logic [15:0] bits;   // bit k = k-th bit on the line (start first)
        int          nbits;
        int          gap;    // required cycles from previous done sample to this start, 0 = any
        logic        abort;  // frame is expected to be cut short by rst
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_v    [4];
    logic       tx_valid [4];
    logic [8:0] tx_data  [4];
    logic       tx_ready [4];
    logic       tx_busy  [4];
    logic       tx_done  [4];
    logic       uart_out [4];

    exp_t expq [4][$];
    int   pending [4];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : u
        localparam int CPB = (g == 0) ? 434 : 4;
        localparam int DB  = (g == 3) ? 7 : 8;
        localparam int PE  = (g == 1 || g == 2) ? 1 : 0;
        localparam int PO  = (g == 2) ? 1 : 0;
        localparam int SB  = (g == 3) ? 2 : 1;

        uart_tx_cfg #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (DB),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB)
        ) dut (
            .clk     (clk),
            .rst     (rst_v[g]),
            .tx_valid(tx_valid[g]),
            .tx_data (tx_data[g][DB-1:0]),
            .tx_ready(tx_ready[g]),
            .tx_busy (tx_busy[g]),
            .tx_done (tx_done[g]),
            .uart_out(uart_out[g])
        );

        initial begin : mon
            exp_t e;
            int   last_done;
            int   bad;
            bit   aborted;
            last_done = 0;
            forever begin
                @(posedge clk); #1;
                if (tx_done[g] === 1'b1) begin
                    n_cmp++; n_fail++;
                    $display("FAIL spurious_done[%0d]: tx_done=1 at cycle %0d, required 0", g, cyc);
                end
                if (rst_v[g] === 1'b0 && tx_busy[g] === 1'b1 && uart_out[g] === 1'b0) begin
                    n_cmp++;
                    if (expq[g].size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_frame[%0d]: frame started at cycle %0d, required none", g, cyc);
                        while (tx_busy[g] === 1'b1) begin @(posedge clk); #1; end
                    end else begin
                        e = expq[g].pop_front();
                        if (e.gap != 0) begin
                            n_cmp++;
                            if (cyc - last_done != e.gap) begin
                                n_fail++;
                                $display("FAIL gap[%0d]: got %0d cycles, required %0d", g, cyc - last_done, e.gap);
                            end
                        end
                        bad = 0; aborted = 0;
                        for (int k = 0; k < e.nbits * CPB; k++) begin
                            if (k != 0) begin @(posedge clk); #1; end
                            if (rst_v[g] === 1'b1) begin aborted = 1; break; end
                            if (uart_out[g] !== e.bits[k / CPB] || tx_done[g] !== 1'b0 ||
                                tx_busy[g] !== 1'b1 || tx_ready[g] !== 1'b0) begin
                                if (bad == 0)
                                    $display("FAIL frame[%0d] sample %0d: uart_out=%0b done=%0b busy=%0b ready=%0b, required uart_out=%0b done=0 busy=1 ready=0",
                                             g, k, uart_out[g], tx_done[g], tx_busy[g], tx_ready[g], e.bits[k / CPB]);
                                bad++;
                            end
                        end
                        if (bad != 0) n_fail++;
                        n_cmp++;
                        if (aborted) begin
                            if (!e.abort || uart_out[g] !== 1'b1 || tx_ready[g] !== 1'b1 ||
                                tx_busy[g] !== 1'b0 || tx_done[g] !== 1'b0) begin
                                n_fail++;
                                $display("FAIL abort[%0d]: uart_out=%0b ready=%0b busy=%0b done=%0b expected_abort=%0b, required 1 1 0 0 with abort expected",
                                         g, uart_out[g], tx_ready[g], tx_busy[g], tx_done[g], e.abort);
                            end
                        end else begin
                            @(posedge clk); #1;
                            if (e.abort || tx_done[g] !== 1'b1 || uart_out[g] !== 1'b1 ||
                                tx_ready[g] !== 1'b1 || tx_busy[g] !== 1'b0) begin
                                n_fail++;
                                $display("FAIL done[%0d]: done=%0b uart_out=%0b ready=%0b busy=%0b abort_expected=%0b, required 1 1 1 0 without abort",
                                         g, tx_done[g], uart_out[g], tx_ready[g], tx_busy[g], e.abort);
                            end
                            last_done = cyc;
                        end
                        pending[g]--;
                    end
                end
            end
        end
    end

    task automatic expect_frame(input int g, input logic [15:0] bits, input int nb,
                                input int gap, input logic abort);
        exp_t e;
        e.bits = bits; e.nbits = nb; e.gap = gap; e.abort = abort;
        expq[g].push_back(e);
        pending[g]++;
    endtask

    // Issues one word to an idle instance; d2 is driven on tx_data right after the accept.
    task automatic send(input int g, input logic [8:0] d, input logic [8:0] d2,
                        input logic [15:0] bits, input int nb, input logic abort);
        expect_frame(g, bits, nb, 0, abort);
        @(negedge clk);
        tx_valid[g] = 1'b1;
        tx_data[g]  = d;
        @(negedge clk);
        tx_valid[g] = 1'b0;
        tx_data[g]  = d2;
        n_cmp++;
        if (tx_busy[g] !== 1'b1 || tx_ready[g] !== 1'b0 || uart_out[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL accept[%0d]: busy=%0b ready=%0b uart_out=%0b, required 1 0 0",
                     g, tx_busy[g], tx_ready[g], uart_out[g]);
        end
    endtask

    task automatic drain(input int g, input int budget);
        int n;
        n = 0;
        while (pending[g] != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pending[g] != 0) begin
            n_fail++;
            $display("FAIL drain[%0d]: %0d frames outstanding, required 0", g, pending[g]);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        for (int g = 0; g < 4; g++) begin
            rst_v[g] = 1'b1; tx_valid[g] = 1'b0; tx_data[g] = '0; pending[g] = 0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (uart_out[g] !== 1'b1 || tx_ready[g] !== 1'b1 || tx_busy[g] !== 1'b0 || tx_done[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: uart_out=%0b ready=%0b busy=%0b done=%0b, required 1 1 0 0",
                         g, uart_out[g], tx_ready[g], tx_busy[g], tx_done[g]);
            end
        end
        for (int g = 0; g < 4; g++) rst_v[g] = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1/434, 0x55: 0 1010 1010 1 on the line.
        send(0, 9'h055, 9'h055, 16'h02AA, 10, 1'b0);
        drain(0, 5000);
        // 8E1/4, 0x07: three ones -> parity 1.
        send(1, 9'h007, 9'h007, 16'h060E, 11, 1'b0);
        drain(1, 200);
        // 8O1/4, 0x07 -> parity 0; 0xA5 (four ones) -> parity 1.
        send(2, 9'h007, 9'h007, 16'h040E, 11, 1'b0);
        drain(2, 200);
        send(2, 9'h0A5, 9'h0A5, 16'h074A, 11, 1'b0);
        drain(2, 200);
        // 7N2/4, 0x7F: start, seven ones, two stop bits.
        send(3, 9'h07F, 9'h07F, 16'h03FE, 10, 1'b0);
        drain(3, 200);

        // Back-to-back on 8E1: 0xA5 then 0x3C with tx_valid held; one idle-high cycle between.
        expect_frame(1, 16'h054A, 11, 0, 1'b0);
        expect_frame(1, 16'h0478, 11, 1, 1'b0);
        @(negedge clk);
        tx_valid[1] = 1'b1;
        tx_data[1]  = 9'h0A5;
        @(negedge clk);
        tx_data[1]  = 9'h03C;
        n = 0;
        while (tx_ready[1] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tx_valid[1] = 1'b0;
        // Pulses while busy must not produce a third frame.
        for (int p = 0; p < 3; p++) begin
            repeat (5) @(negedge clk);
            tx_valid[1] = 1'b1;
            tx_data[1]  = 9'h0F0;
            @(negedge clk);
            tx_valid[1] = 1'b0;
        end
        drain(1, 400);

        // tx_data changed right after accept: 0x12 must go out.
        send(1, 9'h012, 9'h0FF, 16'h0424, 11, 1'b0);
        drain(1, 200);

        // Reset during data bit 3 (cycles 16..19 of the frame), then a clean 0x81.
        send(1, 9'h0A5, 9'h0A5, 16'h054A, 11, 1'b1);
        repeat (17) @(negedge clk);
        rst_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0;
        drain(1, 50);
        send(1, 9'h081, 9'h081, 16'h0502, 11, 1'b0);
        drain(1, 200);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
